// File: rtl/riscv_pkg.sv
// Shared core types: opcodes, memory-arbiter states and requester ids.
// Width defaults for the shared instruction/data memory port.
package riscv_pkg;

   localparam int data_width_p = 32;
   localparam int addr_p       = 10;
   localparam int byte_addr_p  = 12;

   typedef enum logic [3:0] {
      ADD, ADDI, LW, SW, LBU, SB, BEQ, JAL
   } t_risc_v_op;

   typedef enum logic [2:0] {
      IDLE, FETCH, LOAD, STORE, ERR
   } t_arb_state;

   typedef enum logic {
      REQ_IF, REQ_D
   } t_requester;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte lane helper: zero-extended byte extract and byte merge
// into a memory word, selected by a 2-bit little-endian offset.
module mem_byte_lane #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] word_i,
   input  logic [1:0]        off_i,
   input  logic [7:0]        byte_i,
   output logic [DATA_W-1:0] ext_o,
   output logic [DATA_W-1:0] merged_o
);

   logic [4:0] sh;

   assign sh = {off_i, 3'b000};

   always_comb begin
      ext_o            = '0;
      ext_o[7:0]       = word_i[sh +: 8];
      merged_o         = word_i;
      merged_o[sh +: 8] = byte_i;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store (LBU, SB).
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data-first.
module mem_port_arbiter
   import riscv_pkg::*;
#(
   parameter int DATA_W  = data_width_p,
   parameter int ADDR_W  = addr_p,
   parameter int BADDR_W = byte_addr_p
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_req_i,
   input  logic [BADDR_W-1:0] if_addr_i,
   output logic               if_gnt_o,
   output logic               if_rvalid_o,
   output logic [DATA_W-1:0]  if_rdata_o,
   input  logic               d_req_i,
   input  t_risc_v_op         d_op_i,
   input  logic [BADDR_W-1:0] d_addr_i,
   input  logic [7:0]         d_wdata_i,
   output logic               d_gnt_o,
   output logic               d_done_o,
   output logic [DATA_W-1:0]  d_rdata_o,
   output logic               d_err_o,
   output logic               mem_en_o,
   output logic               mem_we_o,
   output logic [ADDR_W-1:0]  mem_addr_o,
   output logic [DATA_W-1:0]  mem_wdata_o,
   input  logic [DATA_W-1:0]  mem_rdata_i
);

   t_arb_state        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        off_q, off_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              data_wins;
   logic              pick_d;
   logic              pick_if;
   logic [DATA_W-1:0] lane_ext;
   logic [DATA_W-1:0] lane_merged;
   logic              unused_ok;

   assign unused_ok = &{1'b0, if_addr_i[1:0]};

`ifdef MEM_ARB_RR_EN
   t_requester last_q, last_d;

   assign data_wins = (last_q == REQ_IF);
`else
   assign data_wins = 1'b1;
`endif

   assign pick_d  = d_req_i && (data_wins || !if_req_i);
   assign pick_if = if_req_i && !pick_d;

   mem_byte_lane #(
      .DATA_W(DATA_W)
   ) u_lane (
      .word_i  (mem_rdata_i),
      .off_i   (off_q),
      .byte_i  (wdata_q),
      .ext_o   (lane_ext),
      .merged_o(lane_merged)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      off_d       = off_q;
      wdata_d     = wdata_q;
`ifdef MEM_ARB_RR_EN
      last_d      = last_q;
`endif
      if_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      if_rdata_o  = '0;
      d_gnt_o     = 1'b0;
      d_done_o    = 1'b0;
      d_rdata_o   = '0;
      d_err_o     = 1'b0;
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      // Outputs are forced quiet while reset is held.
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (pick_d) begin
                  d_gnt_o = 1'b1;
                  addr_d  = d_addr_i[BADDR_W-1:2];
                  off_d   = d_addr_i[1:0];
                  wdata_d = d_wdata_i;
`ifdef MEM_ARB_RR_EN
                  last_d  = REQ_D;
`endif
                  if (d_op_i == LBU || d_op_i == SB) begin
                     mem_en_o   = 1'b1;
                     mem_addr_o = d_addr_i[BADDR_W-1:2];
                     state_d    = (d_op_i == SB) ? STORE : LOAD;
                  end else begin
                     state_d = ERR;
                  end
               end else if (pick_if) begin
                  if_gnt_o   = 1'b1;
                  mem_en_o   = 1'b1;
                  mem_addr_o = if_addr_i[BADDR_W-1:2];
                  addr_d     = if_addr_i[BADDR_W-1:2];
`ifdef MEM_ARB_RR_EN
                  last_d     = REQ_IF;
`endif
                  state_d    = FETCH;
               end
            end
            FETCH: begin
               if_rvalid_o = 1'b1;
               if_rdata_o  = mem_rdata_i;
               state_d     = IDLE;
            end
            LOAD: begin
               d_done_o  = 1'b1;
               d_rdata_o = lane_ext;
               state_d   = IDLE;
            end
            STORE: begin
               mem_en_o    = 1'b1;
               mem_we_o    = 1'b1;
               mem_addr_o  = addr_q;
               mem_wdata_o = lane_merged;
               d_done_o    = 1'b1;
               state_d     = IDLE;
            end
            ERR: begin
               d_done_o = 1'b1;
               d_err_o  = 1'b1;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         off_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         off_q   <= off_d;
         wdata_q <= wdata_d;
      end
   end

`ifdef MEM_ARB_RR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= REQ_IF;
      end else begin
         last_q <= last_d;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus random
// ops against a word-array reference model of memory and arbitration.
module tb_mem_port_arbiter;
   import riscv_pkg::*;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [11:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   t_risc_v_op  d_op;
   logic [11:0] d_addr;
   logic [7:0]  d_wdata;
   logic        d_gnt;
   logic        d_done;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        mem_en;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [1024];
   bit          written [1024];
   logic [31:0] ref_mem [1024];
   bit          ref_last_d;

   mem_port_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .if_req_i   (if_req),
      .if_addr_i  (if_addr),
      .if_gnt_o   (if_gnt),
      .if_rvalid_o(if_rvalid),
      .if_rdata_o (if_rdata),
      .d_req_i    (d_req),
      .d_op_i     (d_op),
      .d_addr_i   (d_addr),
      .d_wdata_i  (d_wdata),
      .d_gnt_o    (d_gnt),
      .d_done_o   (d_done),
      .d_rdata_o  (d_rdata),
      .d_err_o    (d_err),
      .mem_en_o   (mem_en),
      .mem_we_o   (mem_we),
      .mem_addr_o (mem_addr),
      .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] seed(input logic [9:0] a);
      if (a == 10'd4) return 32'h0050_0093;
      if (a == 10'd8) return 32'hA1B2_C3D4;
      return ({22'b0, a} * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
         end else begin
            mem_rdata <= written[mem_addr] ? mem[mem_addr] : seed(mem_addr);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_if_gnt"}, if_gnt, 0);
      chk({tag, "_d_gnt"}, d_gnt, 0);
      chk({tag, "_rvalid"}, if_rvalid, 0);
      chk({tag, "_rdata"}, if_rdata, 0);
      chk({tag, "_done"}, d_done, 0);
      chk({tag, "_d_rdata"}, d_rdata, 0);
      chk({tag, "_err"}, d_err, 0);
      chk({tag, "_mem_en"}, mem_en, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
   endtask

   task automatic fetch(input logic [11:0] a);
      int w;
      w = int'(a) / 4;
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = a;
      d_req   = 1'b0;
      #1;
      chk("f_gnt", if_gnt, 1);
      chk("f_d_gnt", d_gnt, 0);
      chk("f_en", mem_en, 1);
      chk("f_we", mem_we, 0);
      chk("f_addr", mem_addr, w);
      chk("f_rvalid_t", if_rvalid, 0);
      ref_last_d = 1'b0;
      @(negedge clk);
      if_req  = 1'b0;
      if_addr = 12'($urandom);
      #1;
      chk("f_rvalid", if_rvalid, 1);
      chk("f_rdata", if_rdata, ref_mem[w]);
      chk("f_gnt_busy", if_gnt, 0);
   endtask

   task automatic dop(input t_risc_v_op op, input logic [11:0] a,
                      input logic [7:0] b);
      int          w;
      int          sh;
      logic [31:0] old;
      logic [31:0] nw;
      bit          acc;
      w   = int'(a) / 4;
      sh  = (int'(a) % 4) * 8;
      old = ref_mem[w];
      acc = (op == LBU) || (op == SB);
      @(negedge clk);
      d_req   = 1'b1;
      d_op    = op;
      d_addr  = a;
      d_wdata = b;
      if_req  = 1'b0;
      #1;
      chk("d_gnt", d_gnt, 1);
      chk("d_if_gnt", if_gnt, 0);
      chk("d_en", mem_en, acc);
      chk("d_we", mem_we, 0);
      if (acc) chk("d_addr", mem_addr, w);
      chk("d_done_t", d_done, 0);
      ref_last_d = 1'b1;
      @(negedge clk);
      d_req   = 1'b0;
      d_op    = ADD;
      d_addr  = 12'($urandom);
      d_wdata = 8'($urandom);
      #1;
      chk("d_done", d_done, 1);
      chk("d_err", d_err, !acc);
      chk("d_gnt_busy", d_gnt, 0);
      if (op == LBU) chk("lbu_rdata", d_rdata, (old >> sh) & 32'hFF);
      else           chk("d_rdata_zero", d_rdata, 0);
      if (op == SB) begin
         nw = (old & ~(32'hFF << sh)) | ({24'b0, b} << sh);
         chk("sb_en", mem_en, 1);
         chk("sb_we", mem_we, 1);
         chk("sb_addr", mem_addr, w);
         chk("sb_wdata", mem_wdata, nw);
         ref_mem[w] = nw;
      end else begin
         chk("d_no_access", mem_en, 0);
      end
   endtask

   t_risc_v_op err_ops [6];
   bit         exp_d;

   initial begin
      err_ops = '{ADD, ADDI, LW, SW, BEQ, JAL};
      for (int i = 0; i < 1024; i++) ref_mem[i] = seed(10'(i));
      rst     = 1'b1;
      if_req  = 1'b1;
      if_addr = 12'h010;
      d_req   = 1'b1;
      d_op    = LBU;
      d_addr  = 12'h023;
      d_wdata = 8'h00;
      #1;
      chk_quiet("rst0");
      @(negedge clk);
      #1;
      chk_quiet("rst1");
      if_req = 1'b0;
      d_req  = 1'b0;
      @(negedge clk);
      rst        = 1'b0;
      ref_last_d = 1'b0;

      fetch(12'h010);
      dop(LBU, 12'h023, 8'h00);
      dop(SB, 12'h020, 8'h44);
      dop(SB, 12'h021, 8'h33);
      dop(SB, 12'h022, 8'h22);
      dop(SB, 12'h023, 8'h11);
      dop(SB, 12'h021, 8'h5E);
      fetch(12'h020);
      dop(ADDI, 12'h020, 8'hFF);
      fetch(12'h020);

      // Both requesters held across four grants.
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 12'h010;
      d_req   = 1'b1;
      d_op    = LBU;
      d_addr  = 12'h023;
      for (int k = 0; k < 4; k++) begin
         #1;
`ifdef MEM_ARB_RR_EN
         exp_d = (ref_last_d == 1'b0);
`else
         exp_d = 1'b1;
`endif
         chk("arb_d_gnt", d_gnt, exp_d);
         chk("arb_if_gnt", if_gnt, !exp_d);
         ref_last_d = exp_d;
         @(negedge clk);
         #1;
         chk("arb_done", d_done, exp_d);
         chk("arb_rvalid", if_rvalid, !exp_d);
         if (exp_d) chk("arb_lbu", d_rdata, (ref_mem[8] >> 24) & 32'hFF);
         else       chk("arb_fetch", if_rdata, ref_mem[4]);
         chk("arb_no_gnt", {30'b0, if_gnt, d_gnt}, 0);
         @(negedge clk);
      end
      d_req = 1'b0;
      #1;
      chk("arb_if_after", if_gnt, 1);
      @(negedge clk);
      if_req = 1'b0;
      #1;
      chk("arb_if_rvalid", if_rvalid, 1);
      chk("arb_if_rdata", if_rdata, ref_mem[4]);
      ref_last_d = 1'b0;

      // Reset lands on the STORE cycle; the write must be dropped.
      @(negedge clk);
      d_req   = 1'b1;
      d_op    = SB;
      d_addr  = 12'h025;
      d_wdata = 8'hC7;
      #1;
      chk("rst_sb_gnt", d_gnt, 1);
      @(negedge clk);
      d_req = 1'b0;
      rst   = 1'b1;
      #1;
      chk_quiet("rst_mid");
      @(negedge clk);
      rst        = 1'b0;
      ref_last_d = 1'b0;
      fetch(12'h024);
      dop(LBU, 12'h025, 8'h00);

      for (int i = 0; i < 120; i++) begin
         logic [11:0] a;
         a = 12'($urandom_range(0, 63));
         case ($urandom_range(0, 3))
            0:       fetch(a);
            1:       dop(LBU, a, 8'h00);
            2:       dop(SB, a, 8'($urandom));
            default: dop(err_ops[$urandom_range(0, 5)], a, 8'($urandom));
         endcase
      end
      for (int i = 0; i < 16; i++) fetch(12'(i * 4));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
